// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: state enum, opcodes, functs, mux selects, ALU codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_ALUWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: purely combinational (0 cycles), no flow control; aluop/funct -> alucontrol.
// Unknown funct falls back to add and raises funct_illegal.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS Moore control FSM; outputs combinational from state (plus zero/funct), no backpressure.
// Optional MIPS_BNE_EN adds bne through the beq execute state with an inverted zero test.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t state, cur, next;
  aluop_t aluop;
  logic   pcwrite, branch, take, op_illegal, funct_illegal;
  logic   ir_w, reg_w, mem_w;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Under reset the outputs decode as FETCH regardless of the stale state register.
  assign cur = reset ? S_FETCH : state;

  always_comb begin
    next       = S_FETCH;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    op_illegal = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    case (cur)
      S_FETCH: begin
        ir_w    = 1'b1;
        pcwrite = 1'b1;
        alusrcb = SRCB_FOUR;
        next    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE:     next = S_RTYPEEX;
          OP_BEQ:       next = S_BEQEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       next = S_BEQEX;
`endif
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JEX;
          default:      op_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        reg_w    = 1'b1;
      end
      S_MEMWR: begin
        iord  = 1'b1;
        mem_w = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        reg_w  = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = S_ADDIWB;
      end
      S_ADDIWB: reg_w = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

  // IR still holds the branch opcode during the execute cycle, so it selects the zero polarity.
`ifdef MIPS_BNE_EN
  assign take = (op == OP_BNE) ? ~zero : zero;
`else
  assign take = zero;
`endif

  mips_aludec u_aludec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  assign pcen     = ~reset & (pcwrite | (branch & take));
  assign irwrite  = ~reset & ir_w;
  assign regwrite = ~reset & reg_w;
  assign memwrite = ~reset & mem_w;
  assign illegal  = ~reset & (op_illegal | funct_illegal);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed plus random instruction streams against a per-instruction cycle-table model of the controller.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctl_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_BNE = 4, C_ADDI = 5, C_J = 6, C_ILL = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
`ifdef MIPS_BNE_EN
      6'b000101: return C_BNE;
`endif
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int cpi(input int c);
    case (c)
      C_LW:                      return 5;
      C_SW, C_R, C_ADDI:         return 4;
      C_BEQ, C_BNE, C_J:         return 3;
      default:                   return 2;
    endcase
  endfunction

  // {valid, alucontrol} for an R-type funct
  function automatic logic [3:0] rfunc(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  // Expected control word for cycle k (0 = fetch) of the instruction (o, f), given zero z.
  function automatic ctl_t model(input logic [5:0] o, input logic [5:0] f, input int k, input logic z);
    ctl_t c;
    int   cls;
    logic [3:0] rf;
    c = '0;
    c.alucontrol = 3'b010;
    cls = classify(o);
    rf  = rfunc(f);
    if (k == 0) begin
      c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1;
    end else if (k == 1) begin
      c.alusrcb = 2'b11; c.illegal = (cls == C_ILL);
    end else begin
      case (cls)
        C_LW, C_SW: begin
          if (k == 2) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          else if (k == 3) begin c.iord = 1'b1; c.memwrite = (cls == C_SW); end
          else begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
        end
        C_R: begin
          if (k == 2) begin c.alusrca = 1'b1; c.alucontrol = rf[2:0]; c.illegal = ~rf[3]; end
          else begin c.regdst = 1'b1; c.regwrite = 1'b1; end
        end
        C_BEQ, C_BNE: begin
          c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
          c.pcen = (cls == C_BEQ) ? z : ~z;
        end
        C_ADDI: begin
          if (k == 2) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
          else c.regwrite = 1'b1;
        end
        C_J: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
        default: c = c;
      endcase
    end
    return c;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol, illegal};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; zf < 0 randomises zero each cycle, otherwise forces it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf);
    int n;
    op    = o;
    funct = f;
    n = cpi(classify(o));
    for (int k = 0; k < n; k++) begin
      zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      #1;
      check($sformatf("op%b_f%b_c%0d_z%0b", o, f, k, zero), model(o, f, k, zero));
      @(negedge clk);
    end
  endtask

  ctl_t       rst_word;
  logic [5:0] ops [8];
  logic [5:0] fns [5];

  initial begin
    rst_word = '0;
    rst_word.alusrcb    = 2'b01;
    rst_word.alucontrol = 3'b010;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    @(negedge clk);
    repeat (2) begin
      #1;
      check("reset_hold", rst_word);
      @(negedge clk);
    end
    reset = 1'b0;

    run_instr(6'b100011, 6'b000000, -1);
    run_instr(6'b101011, 6'b000000, -1);
    run_instr(6'b000100, 6'b000000, 1);
    run_instr(6'b000100, 6'b000000, 0);
    run_instr(6'b000101, 6'b000000, 0);
    run_instr(6'b000101, 6'b000000, 1);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, fns[i], -1);
    run_instr(6'b000000, 6'b111111, -1);
    run_instr(6'b001000, 6'b000000, -1);
    run_instr(6'b000010, 6'b000000, -1);
    run_instr(6'b111111, 6'b000000, -1);

    // Abandon a load in its memory-read cycle.
    op = 6'b100011; funct = 6'b0;
    for (int k = 0; k < 3; k++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("lw_abort_c%0d", k), model(6'b100011, 6'b0, k, zero));
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("reset_in_memrd", rst_word);
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'b000000, 6'b100000, -1);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) o = 6'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(o, f, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Main control unit for the multicycle MIPS core. Sequences the shared datapath (one memory for instructions and data, one ALU, PC/IR/register file) through fetch, decode and execute steps with a Moore state machine and a combinational ALU decoder. Sits inside the core beside the datapath; `top` exposes only the memory-side `memwrite` it produces.

## Interface
Parameters:
- none; encodings come from `mips_pkg`.

Ports:
- `clk` in 1: single core clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: `instr[31:26]` from IR.
- `funct` in 6: `instr[5:0]` from IR.
- `zero` in 1: ALU zero flag.
- `pcen` out 1: PC write enable, `pcwrite | (branch & zero)` (`~zero` for bne).
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: IR load.
- `regwrite` out 1: register-file write.
- `iord` out 1: 0 = PC addresses memory, 1 = ALUOut.
- `memtoreg` out 1: 1 = write-back from Data register.
- `regdst` out 1: 1 = rd, 0 = rt.
- `alusrca` out 1: 0 = PC, 1 = A.
- `alusrcb` out 2: 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- `pcsrc` out 2: 00 ALUResult, 01 ALUOut, 10 jump target.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: one-cycle pulse on undecodable op/funct.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
- DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut). op lw/sw (100011/101011) -> MEMADR; R-type (000000) -> RTYPEEX; beq (000100) -> BEQEX; addi (001000) -> ADDIEX; j (000010) -> JEX; other -> FETCH with `illegal`=1.
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, ALU op from funct -> ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- ALU decode (R-type): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct -> alucontrol=010, `illegal` pulse in RTYPEEX, ALUWB still performed (regwrite=1).
- All outputs not listed in a state are 0 (alusrcb/pcsrc 00, alucontrol 010).

## Timing
- Outputs are combinational from registered state (plus `zero`, `funct`); no input-to-state-register combinational loops.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset: state <= FETCH at the edge where `reset`=1; while `reset`=1, `pcen`, `irwrite`, `regwrite`, `memwrite`, `illegal` forced 0; other outputs follow FETCH decode.
- Reset mid-instruction: abandons instruction; first cycle after deassertion is FETCH with irwrite=1.
- `zero` sampled only in the BEQEX cycle; `pcen` there is same-cycle combinational.

## Configuration
- `MIPS_BNE_EN` defined: op 000101 in DECODE -> BEQEX path with branch-on-not-zero (`pcen = ~zero` in that state), 3 cycles.
- Undefined: op 000101 is illegal (DECODE -> FETCH, `illegal` pulse).

## Structure
- `mips_pkg`: state enum, opcode/funct localparams, `alusrcb`/`pcsrc`/`alucontrol` encodings, 2-bit internal `aluop` type (00 add, 01 sub, 10 funct).
- Sub-module `mips_aludec` (aluop, funct -> alucontrol, funct_illegal); FSM and output decode in `mips_mc_controller`.

## Test plan
- Reset held 2 cycles then released, op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; irwrite=1 only in cycle 1.
- op=101011 -> memwrite=1 with iord=1 exactly in cycle 4; back in FETCH in cycle 5.
- op=000100, zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0.
- op=000000, funct=101010 -> alucontrol=111 in RTYPEEX, regdst=1/regwrite=1 in ALUWB; funct=111111 -> `illegal` pulse in RTYPEEX.
- op=111111 -> `illegal`=1 in DECODE, FETCH next cycle; op=000101 same without `MIPS_BNE_EN`, with it zero=0 -> pcen=1 in cycle 3.
- Assert `reset` during MEMRD of lw -> no regwrite ever issued; FETCH with irwrite=1 first cycle after release.
